rr_priority_encoder: RTL



---
 rtl/rr_priority_encoder.sv | 55 +++++
 1 files changed

// File: rtl/rr_priority_encoder.sv
// rr_priority_encoder: registered fixed/round-robin priority encoder with valid/ready output
// Ports: clk, rst (sync, active-high); req[N] request lines; rr_en selects round-robin search;
// out_ready accepts the grant; out_valid/out_idx/out_onehot carry the held grant.
module rr_priority_encoder #(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         rr_en,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_onehot
);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state, state_nxt;
  logic [W-1:0] ptr, ptr_nxt, start, win;
  logic accept, load;
  int k;
  assign out_valid = state == HOLD;
  assign accept = out_valid && out_ready;
  // back-to-back issue searches from the pointer that this accept is about to write
  assign ptr_nxt = accept && rr_en ? (out_idx == W'(N - 1) ? '0 : out_idx + W'(1)) : ptr;
  assign start = rr_en ? ptr_nxt : '0;
  assign load = (state == IDLE || accept) && |req;
  // ascending search from start, wrapping N-1 -> 0; first hit wins
  always_comb begin
    win = '0;
    k = 0;
    for (int i = N - 1; i >= 0; i--) begin
      k = int'(start) + i;
      k = k >= N ? k - N : k;
      win = req[k] ? W'(k) : win;
    end
  end
  always_comb begin
    state_nxt = state;
    state_nxt = load ? HOLD : accept ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      out_idx <= '0;
      out_onehot <= '0;
    end else begin
      state <= state_nxt;
      ptr <= ptr_nxt;
      out_idx <= load ? win : out_idx;
      out_onehot <= load ? N'(1) << win : accept ? '0 : out_onehot;
    end
  end
endmodule
